femto8_mem_arbiter: RTL and testbench

- Shares the single femto8 memory bus (RAM 0x00-0x7F, ROM 0x80-0xFF) between NREQ bus masters: the CPU, a DMA/loader and a debug port.
- Each master issues one read or write at a time using a req/ack handshake.
- The arbiter selects one master, drives the memory address, write-data and write-enable lines for one access cycle, captures read data, then acks.
- It sits between the masters and the RAM/ROM decode in the test top.

---
 rtl/femto8_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_femto8_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/femto8_mem_arbiter.sv
// Shares the femto8 memory bus between NREQ req/ack masters; one access per 4 cycles.
// Optional macro ARB_FIXED_PRIO_EN: lowest-index requester always wins instead of round-robin.
module femto8_mem_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rdata,
  output logic [1:0]        gnt_id,
  output logic              busy,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_we,
  input  logic [DW-1:0]     mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;
  localparam logic [1:0] S_TURN   = 2'd3;
  localparam logic [1:0] LAST_RST = 2'(NREQ - 1);

  logic [1:0]      state, state_nxt;
  logic [1:0]      last_grant, last_grant_nxt;
  logic [1:0]      gnt_id_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic [DW-1:0]   rdata_nxt;
  logic            busy_nxt;
  logic [AW-1:0]   mem_addr_nxt;
  logic [DW-1:0]   mem_wdata_nxt;
  logic            mem_we_nxt;

  logic            win_found;
  logic [1:0]      win_id;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;

  // Winner selection and mux of the winner's request fields
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_id    = 2'(i);
      end
    end
`else
    // Scan offsets 1..NREQ past last_grant; first requesting port wins
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!win_found && req[i] &&
            (i == ((32'(last_grant) + k + 32'd1) % NREQ))) begin
          win_found = 1'b1;
          win_id    = 2'(i);
        end
      end
    end
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_id == 2'(i)) begin
        win_we    = req_we[i];
        win_addr  = req_addr[i*AW +: AW];
        win_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    gnt_id_nxt     = gnt_id;
    ack_nxt        = '0;
    rdata_nxt      = rdata;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    mem_we_nxt     = 1'b0;
    busy_nxt       = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          gnt_id_nxt     = win_id;
          last_grant_nxt = win_id;
          mem_addr_nxt   = win_addr;
          mem_wdata_nxt  = win_wdata;
          mem_we_nxt     = win_we;
          state_nxt      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // mem_we still reflects the latched request type here
        if (!mem_we) rdata_nxt = mem_rdata;
        for (int unsigned i = 0; i < NREQ; i++) begin
          ack_nxt[i] = (gnt_id == 2'(i));
        end
        state_nxt = S_ACK;
      end
      S_ACK:   state_nxt = S_TURN;
      S_TURN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= LAST_RST;
      gnt_id     <= 2'd0;
      ack        <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      gnt_id     <= gnt_id_nxt;
      ack        <= ack_nxt;
      rdata      <= rdata_nxt;
      busy       <= busy_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      mem_we     <= mem_we_nxt;
    end
  end

endmodule

// File: tb/tb_femto8_mem_arbiter.sv
// Self-checking bench for femto8_mem_arbiter (NREQ=2) with a RAM/ROM model on the memory bus.
module tb_femto8_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic [1:0]  gnt_id;
  logic        busy;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  femto8_mem_arbiter #(.NREQ(2), .AW(8), .DW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .gnt_id(gnt_id), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM at 0x00-0x7F, ROM at 0x80-0xFF with ROM[i] = i ^ 0xA2
  logic [7:0] ram [0:127];
  always @(posedge clk) if (mem_we && !mem_addr[7]) ram[mem_addr[6:0]] <= mem_wdata;
  assign mem_rdata = mem_addr[7] ? (8'(mem_addr[6:0]) ^ 8'hA2) : ram[mem_addr[6:0]];

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    int         port;
    logic [7:0] rdata;
  } exp_t;

  vec_t vecs [12];
  exp_t sb [$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Called at a negedge where ack is nonzero; compares against the scoreboard head
  task automatic pop_ack();
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected ack", 32'(ack), 32'd0);
    end else begin
      e = sb.pop_front();
      check("ack onehot", 32'(ack), 32'(2'b01 << e.port));
      check("gnt_id", 32'(gnt_id), 32'(e.port));
      check("rdata", 32'(rdata), 32'(e.rdata));
    end
  endtask

  task automatic run_txn(input int p, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd);
    exp_t e;
    int busy_cyc = 0;
    int we_cyc   = 0;
    int ack_cnt  = 0;
    @(negedge clk);
    req[p] = 1'b1;
    req_we[p] = we;
    req_addr[p*8 +: 8] = addr;
    req_wdata[p*8 +: 8] = wdata;
    e.port = p;
    e.rdata = exp_rd;
    sb.push_back(e);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("grant mem_addr", 32'(mem_addr), 32'(addr));
        check("grant mem_we", 32'(mem_we), 32'(we));
        if (we) check("grant mem_wdata", 32'(mem_wdata), 32'(wdata));
      end
      if (busy) busy_cyc++;
      if (mem_we) we_cyc++;
      if (ack != 2'b00) begin
        ack_cnt++;
        pop_ack();
        req[p] = 1'b0;
      end
    end
    req[p] = 1'b0;
    check("busy cycles", 32'(busy_cyc), 32'd3);
    check("mem_we cycles", 32'(we_cyc), 32'(we));
    check("ack count", 32'(ack_cnt), 32'd1);
    if (we) check("ram written", 32'(ram[addr[6:0]]), 32'(wdata));
    while (sb.size() != 0) void'(sb.pop_front());
  endtask

  initial begin
    exp_t e;
    int t, last_t, nack, nspur;

    vecs[0]  = '{0, 1'b0, 8'h85, 8'h00, 8'hA7};
    vecs[1]  = '{1, 1'b1, 8'h10, 8'h3C, 8'hA7};
    vecs[2]  = '{0, 1'b0, 8'h10, 8'h00, 8'h3C};
    vecs[3]  = '{1, 1'b0, 8'hFF, 8'h00, 8'hDD};
    vecs[4]  = '{0, 1'b1, 8'h7F, 8'h55, 8'hDD};
    vecs[5]  = '{1, 1'b0, 8'h7F, 8'h00, 8'h55};
    vecs[6]  = '{0, 1'b0, 8'h80, 8'h00, 8'hA2};
    vecs[7]  = '{1, 1'b1, 8'h00, 8'h99, 8'hA2};
    vecs[8]  = '{0, 1'b0, 8'h00, 8'h00, 8'h99};
    vecs[9]  = '{1, 1'b1, 8'h04, 8'h11, 8'h99};
    vecs[10] = '{0, 1'b1, 8'h05, 8'h22, 8'h99};
    vecs[11] = '{1, 1'b0, 8'h05, 8'h00, 8'h22};

    reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst ack", 32'(ack), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst rdata", 32'(rdata), 32'd0);
    check("rst gnt_id", 32'(gnt_id), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Contention from reset: both requests held, port0 dropped after the 4th ack
`ifdef ARB_FIXED_PRIO_EN
    e.port = 0; e.rdata = 8'hA3; repeat (4) sb.push_back(e);
`else
    e.port = 0; e.rdata = 8'hA3; sb.push_back(e);
    e.port = 1; e.rdata = 8'hA0; sb.push_back(e);
    e.port = 0; e.rdata = 8'hA3; sb.push_back(e);
    e.port = 1; e.rdata = 8'hA0; sb.push_back(e);
`endif
    e.port = 1; e.rdata = 8'hA0; sb.push_back(e);
    req_addr = {8'h82, 8'h81};
    req_we = 2'b00;
    req = 2'b11;
    t = 0; last_t = 0; nack = 0;
    for (int c = 0; c < 60 && nack < 5; c++) begin
      @(negedge clk);
      t++;
      if (ack != 2'b00) begin
        pop_ack();
        if (nack > 0) check("ack spacing", 32'(t - last_t), 32'd4);
        last_t = t;
        nack++;
        if (nack == 4) req[0] = 1'b0;
        if (nack == 5) req = 2'b00;
      end
    end
    req = 2'b00;
    check("contention acks", 32'(nack), 32'd5);
    while (sb.size() != 0) void'(sb.pop_front());
    repeat (4) @(negedge clk);

    // Table of single transactions
    for (int i = 0; i < 12; i++)
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

    // Late request change after grant: the latched address must be used
    @(negedge clk);
    req_we[0] = 1'b0; req_addr[7:0] = 8'h04; req[0] = 1'b1;
    e.port = 0; e.rdata = 8'h11; sb.push_back(e);
    @(negedge clk);
    req_addr[7:0] = 8'h05;
    check("late mem_addr", 32'(mem_addr), 32'h04);
    @(negedge clk);
    check("late ack seen", 32'(ack != 2'b00), 32'd1);
    if (ack != 2'b00) pop_ack();
    @(negedge clk);
    check("late turn busy", 32'(busy), 32'd1);
    check("late turn ack", 32'(ack), 32'd0);
    req[0] = 1'b0;
    nspur = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack != 2'b00 || busy) nspur++;
    end
    check("late no regrant", 32'(nspur), 32'd0);
    while (sb.size() != 0) void'(sb.pop_front());

    // Reset during ACCESS of a port1 write to 0x20
    @(negedge clk);
    req_we[1] = 1'b1; req_addr[15:8] = 8'h20; req_wdata[15:8] = 8'h77; req[1] = 1'b1;
    @(negedge clk);
    check("mid access mem_we", 32'(mem_we), 32'd1);
    reset = 1'b1; req = 2'b00;
    @(negedge clk);
    check("mid rst ack", 32'(ack), 32'd0);
    check("mid rst mem_we", 32'(mem_we), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst gnt_id", 32'(gnt_id), 32'd0);
    reset = 1'b0;
    nspur = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack != 2'b00) nspur++;
    end
    check("mid rst no ack", 32'(nspur), 32'd0);
    run_txn(0, 1'b0, 8'h85, 8'h00, 8'hA7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
